// File: rtl/relu_pkg.sv
// Shared definitions for the activation pipeline: mode encodings and fixed-point helpers.
// Latency: none (pure functions and types).
// Backpressure: not applicable.
package relu_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } relu_mode_e;

  // Helpers work on a wide signed scratch type; callers sign-extend into it.
  localparam int CALC_W = 65;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    logic  ovf;
    calc_t val;
  } sat_res_t;

  // Half-up rounding (toward +inf) followed by arithmetic right shift.
  function automatic calc_t round_shift(input calc_t x, input int unsigned sh);
    calc_t half;
    calc_t res;
    if (sh == 0) begin
      res = x;
    end else begin
      half = calc_t'(1) <<< (sh - 1);
      res  = (x + half) >>> sh;
    end
    return res;
  endfunction

  // Clamp x to a signed range of the given width; ovf flags any change.
  function automatic sat_res_t saturate(input calc_t x, input int unsigned width);
    calc_t    hi;
    calc_t    lo;
    sat_res_t r;
    hi    = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo    = -(calc_t'(1) <<< (width - 1));
    r.ovf = 1'b0;
    r.val = x;
    if (x > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (x < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_trunc_pipe_if.sv
// Beat stream into and out of the activation pipeline, with the per-lane saturation flags.
// Latency: none (wires only).
// Backpressure: valid/ready on both the input and output sides.
interface relu_trunc_pipe_if #(
  parameter int ACCUM_DATA_WIDTH = 44,
  parameter int DATA_WIDTH       = 16,
  parameter int NUM_CH           = 4
);
  logic                               in_valid;
  logic                               in_ready;
  logic [NUM_CH*ACCUM_DATA_WIDTH-1:0] in_data;
  logic [1:0]                         mode;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]       out_data;
  logic [NUM_CH-1:0]                  sat_flag;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/relu_lane.sv
// One lane of combinational datapath: round/shift half feeds stage 1, saturate/activate half feeds stage 2.
// Latency: 0 (purely combinational; the top owns all registers).
// Backpressure: none; the top holds its inputs stable when stalled.
module relu_lane
  import relu_pkg::*;
#(
  parameter int                    ACCUM_DATA_WIDTH = 44,
  parameter int                    DATA_WIDTH       = 16,
  parameter int                    FRAC_SHIFT       = 12,
  parameter int                    LEAKY_SHIFT      = 3,
  parameter logic [DATA_WIDTH-1:0] CLIP_MAX         = 16'h6000
) (
  input  logic signed [ACCUM_DATA_WIDTH-1:0] acc,
  output logic signed [ACCUM_DATA_WIDTH:0]   rnd,
  input  logic signed [ACCUM_DATA_WIDTH:0]   rnd_q,
  input  relu_mode_e                         mode,
  output logic signed [DATA_WIDTH-1:0]       y,
  output logic                               sat
);

  calc_t                         rs_full;
  sat_res_t                      sr;
  logic signed [DATA_WIDTH-1:0]  s;
  logic                          lane_unused;

  always_comb begin
    rs_full = round_shift(calc_t'(acc), FRAC_SHIFT);
    rnd     = rs_full[ACCUM_DATA_WIDTH:0];
  end

  always_comb begin
    sr  = saturate(calc_t'(rnd_q), DATA_WIDTH);
    s   = sr.val[DATA_WIDTH-1:0];
    sat = sr.ovf;
    y   = s;
    case (mode)
      MODE_RELU:  if (s < 0) y = '0;
      MODE_LEAKY: if (s < 0) y = s >>> LEAKY_SHIFT;
      MODE_CLIP: begin
        if (s < 0)                        y = '0;
        else if (s > $signed(CLIP_MAX))   y = $signed(CLIP_MAX);
      end
      default: ;
    endcase
  end

  // Upper scratch bits are pure sign extension once the clamp/shift has run.
  assign lane_unused = ^{rs_full[CALC_W-1:ACCUM_DATA_WIDTH+1], sr.val[CALC_W-1:DATA_WIDTH]};

endmodule

// File: rtl/relu_trunc_pipe.sv
// Multi-lane round/shift, saturate and activation stage with saturation statistics.
// Latency: 2 cycles from accepted beat to out_valid, 1 beat/cycle throughput.
// Backpressure: single global advance; in_ready drops whenever the output is held.
module relu_trunc_pipe
  import relu_pkg::*;
#(
  parameter int                    ACCUM_DATA_WIDTH = 44,
  parameter int                    DATA_WIDTH       = 16,
  parameter int                    NUM_CH           = 4,
  parameter int                    FRAC_SHIFT       = 12,
  parameter int                    LEAKY_SHIFT      = 3,
  parameter logic [DATA_WIDTH-1:0] CLIP_MAX         = 16'h6000,
  parameter int                    SAT_CNT_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  relu_trunc_pipe_if.slave         bus,
  input  logic                     sat_clear,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  localparam int LW = ACCUM_DATA_WIDTH + 1;
  localparam int CW = SAT_CNT_WIDTH + 1;

  logic                         adv;
  logic                         s1_vld;
  relu_mode_e                   s1_mode;
  logic signed [LW-1:0]         s1_rnd [NUM_CH];
  logic signed [LW-1:0]         rnd_c  [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] y_c;
  logic [NUM_CH-1:0]            sat_c;
  logic                         out_vld_q;
  logic [NUM_CH*DATA_WIDTH-1:0] out_dat_q;
  logic [NUM_CH-1:0]            sat_q;
  logic [SAT_CNT_WIDTH-1:0]     cnt_q;
  logic [CW-1:0]                pop;
  logic [CW-1:0]                cnt_sum;

  assign adv           = !out_vld_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;
  assign bus.sat_flag  = sat_q;
  assign sat_count     = cnt_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    relu_lane #(
      .ACCUM_DATA_WIDTH(ACCUM_DATA_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .FRAC_SHIFT      (FRAC_SHIFT),
      .LEAKY_SHIFT     (LEAKY_SHIFT),
      .CLIP_MAX        (CLIP_MAX)
    ) u_lane (
      .acc  (bus.in_data[g*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]),
      .rnd  (rnd_c[g]),
      .rnd_q(s1_rnd[g]),
      .mode (s1_mode),
      .y    (y_c[g*DATA_WIDTH +: DATA_WIDTH]),
      .sat  (sat_c[g])
    );
  end

  // Data registers only load under a valid beat so the held output never shows bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_mode   <= MODE_BYPASS;
      for (int i = 0; i < NUM_CH; i++) s1_rnd[i] <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sat_q     <= '0;
    end else if (adv) begin
      s1_vld    <= bus.in_valid;
      out_vld_q <= s1_vld;
      if (bus.in_valid) begin
        s1_mode <= relu_mode_e'(bus.mode);
        for (int i = 0; i < NUM_CH; i++) s1_rnd[i] <= rnd_c[i];
      end
      if (s1_vld) begin
        out_dat_q <= y_c;
        sat_q     <= sat_c;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop = pop + CW'(sat_q[i]);
    cnt_sum = {1'b0, cnt_q} + pop;
  end

  always_ff @(posedge clock) begin
    if (reset || sat_clear) begin
      cnt_q <= '0;
    end else if (out_vld_q && bus.out_ready) begin
      cnt_q <= cnt_sum[SAT_CNT_WIDTH] ? '1 : cnt_sum[SAT_CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_relu_trunc_pipe.sv
// Directed-vector bench for relu_trunc_pipe with a queue scoreboard and an independent output monitor.
module tb_relu_trunc_pipe;
  import relu_pkg::*;

  localparam int ACC = 44;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CW  = 16;

  typedef logic [NCH*ACC-1:0] in_bus_t;
  typedef logic [NCH*DW-1:0]  out_bus_t;
  typedef struct packed {
    out_bus_t         dat;
    logic [NCH-1:0]   flg;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sat_clear = 1'b0;
  logic [CW-1:0] sat_count;

  relu_trunc_pipe_if #(.ACCUM_DATA_WIDTH(ACC), .DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  relu_trunc_pipe #(
    .ACCUM_DATA_WIDTH(ACC), .DATA_WIDTH(DW), .NUM_CH(NCH), .FRAC_SHIFT(12),
    .LEAKY_SHIFT(3), .CLIP_MAX(16'h6000), .SAT_CNT_WIDTH(CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  always #5 clock = ~clock;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  localparam logic signed [ACC-1:0] BIG = 44'sh100_0000_0000;

  function automatic in_bus_t pk(input logic [ACC-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic out_bus_t po(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a beat is delivered at the next rising edge when valid and ready are both high now.
  always @(negedge clock) begin
    exp_t              e;
    logic [CW:0]       tmp;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got data %h flags %b, expected no beat", bus.out_data, bus.sat_flag);
      end else begin
        e = q.pop_front();
        check("beat_data", 64'(bus.out_data), 64'(e.dat));
        check("beat_flags", 64'(bus.sat_flag), 64'(e.flg));
        tmp     = {1'b0, exp_cnt} + (CW+1)'($countones(e.flg));
        exp_cnt = tmp[CW] ? '1 : tmp[CW-1:0];
      end
    end
  end

  task automatic send(input in_bus_t d, input logic [1:0] m, input out_bus_t ed, input logic [NCH-1:0] ef);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.mode     = m;
    while (!ok && n < 200) begin
      if (bus.in_ready) begin
        @(posedge clock);
        q.push_back('{dat: ed, flg: ef});
        ok = 1'b1;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    check("in_accept", 64'(ok), 64'(1));
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_left", 64'(q.size()), 64'(0));
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    check("rst_sat_flag",  64'(bus.sat_flag),  64'(0));
    check("rst_sat_count", 64'(sat_count),     64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    reset = 1'b0;

    // Round/shift under ReLU, with a latency check on the first beat.
    send(pk(44'sh1800, 44'sh17FF, -44'sh1800, 44'sh0), 2'd1, po(16'h0002, 16'h0001, 16'h0000, 16'h0000), 4'b0000);
    idle();
    check("lat_cycle1_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'(1));
    check("lat_cycle2_flags", 64'(bus.sat_flag),  64'(0));
    drain();
    check("cnt_after_round", 64'(sat_count), 64'(0));

    // Saturation in bypass mode.
    send(pk(BIG, 44'sh0, 44'sh0, 44'sh0),  2'd0, po(16'h7FFF, 16'h0, 16'h0, 16'h0), 4'b0001);
    send(pk(-BIG, 44'sh0, 44'sh0, 44'sh0), 2'd0, po(16'h8000, 16'h0, 16'h0, 16'h0), 4'b0001);
    idle();
    drain();
    check("cnt_after_sat", 64'(sat_count), 64'(2));

    // Rounding/saturation edges, then leaky and clip with a mode change every beat.
    send(pk(-44'sh1800, -44'sh1801, 44'sh7FFF000, 44'sh7FFF800), 2'd0,
         po(16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h7FFF), 4'b1000);
    send(pk(-44'sh8000000, -44'sh8001000, 44'sh7FF, 44'sh800), 2'd0,
         po(16'h8000, 16'h8000, 16'h0000, 16'h0001), 4'b0010);
    send(pk(-44'sh10000, -44'sh9000, 44'sh5000, BIG), 2'd2,
         po(16'hFFFE, 16'hFFFE, 16'h0005, 16'h7FFF), 4'b1000);
    send(pk(44'sh7000000, 44'sh5000000, -44'sh10000, BIG), 2'd3,
         po(16'h6000, 16'h5000, 16'h0000, 16'h6000), 4'b1000);
    idle();
    drain();
    check("cnt_after_modes", 64'(sat_count), 64'(exp_cnt));

    // Six-beat stream with a three-cycle output stall in the middle.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          in_bus_t  d;
          out_bus_t e;
          for (int i = 0; i < NCH; i++) begin
            d[i*ACC +: ACC] = ACC'((k*4 + i + 1) * 4096);
            e[i*DW +: DW]   = DW'(k*4 + i + 1);
          end
          send(d, 2'd0, e, 4'b0000);
        end
        idle();
      end
      begin
        int       n;
        out_bus_t held;
        n = 0;
        @(negedge clock);
        while (!bus.out_valid && n < 50) begin
          @(negedge clock);
          n++;
        end
        check("bp_first_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(negedge clock);
        held = bus.out_data;
        check("bp_in_ready_0", 64'(bus.in_ready), 64'(0));
        for (int j = 1; j < 3; j++) begin
          @(negedge clock);
          check("bp_in_ready", 64'(bus.in_ready),  64'(0));
          check("bp_valid",    64'(bus.out_valid), 64'(1));
          check("bp_stable",   64'(bus.out_data),  64'(held));
        end
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("cnt_after_bp", 64'(sat_count), 64'(exp_cnt));

    // Clear colliding with a saturating transfer.
    begin
      int n;
      n = 0;
      send(pk(-BIG, 44'sh0, 44'sh0, 44'sh0), 2'd0, po(16'h8000, 16'h0, 16'h0, 16'h0), 4'b0001);
      idle();
      while (!bus.out_valid && n < 50) begin
        @(negedge clock);
        n++;
      end
      check("clr_valid_seen", 64'(bus.out_valid), 64'(1));
      sat_clear = 1'b1;
      @(posedge clock);
      #1 sat_clear = 1'b0;
      exp_cnt = '0;
      @(negedge clock);
      check("clr_wins", 64'(sat_count), 64'(0));
    end

    // Drive the counter into its ceiling and confirm it sticks.
    for (int k = 0; k < 16390; k++)
      send(pk(BIG, BIG, BIG, BIG), 2'd0, po(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'b1111);
    idle();
    drain();
    check("cnt_ceiling", 64'(sat_count), 64'(16'hFFFF));
    check("cnt_ceiling_model", 64'(sat_count), 64'(exp_cnt));
    send(pk(BIG, 44'sh0, 44'sh0, 44'sh0), 2'd0, po(16'h7FFF, 16'h0, 16'h0, 16'h0), 4'b0001);
    idle();
    drain();
    check("cnt_sticks", 64'(sat_count), 64'(16'hFFFF));

    // Reset with two beats in flight.
    send(pk(44'sh1000, 44'sh0, 44'sh0, 44'sh0), 2'd0, po(16'h1, 16'h0, 16'h0, 16'h0), 4'b0000);
    send(pk(BIG, 44'sh0, 44'sh0, 44'sh0),       2'd0, po(16'h7FFF, 16'h0, 16'h0, 16'h0), 4'b0001);
    #1;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    exp_cnt = '0;
    @(posedge clock);
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_out_data",  64'(bus.out_data),  64'(0));
    check("mid_rst_sat_count", 64'(sat_count),     64'(0));
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
    reset = 1'b0;
    send(pk(44'sh3000, -44'sh3000, 44'sh1000, 44'sh0), 2'd1, po(16'h0003, 16'h0000, 16'h0001, 16'h0000), 4'b0000);
    idle();
    check("post_rst_lat1", 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check("post_rst_lat2", 64'(bus.out_valid), 64'(1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
